frog_memctl: RTL and testbench

Memory controller and program loader for the frog 4-bit CPU. Owns a 128×4 nibble store and decodes the CPU's 8-bit output bus (7-bit address plus write flag) into reads and two-phase writes. Feeds read data back into the CPU's 4-bit data input. Also provides a host-side nibble-stream loader that holds the CPU in reset while a program is written.

---
 rtl/frog_pkg.sv | 35 +++
 rtl/frog_mem128x4.sv | 28 ++
 rtl/frog_memctl.sv | 112 +++++++++++
 tb/tb_frog_memctl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// frog shared definitions: FSM state enums, CPU bus field
// positions and frog opcode constants for program assembly.
package frog_pkg;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    RELEASE
  } top_t;

  typedef enum logic {
    WIDLE,
    WDATA
  } wst_t;

  localparam int WCYC_BIT = 7;
  localparam int ADDR_MSB = 6;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_OUT = 4'hC;
  localparam logic [3:0] OP_IN  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/frog_mem128x4.sv
// Nibble store: async-reset clear, one sync write port,
// one combinational read port (raddr -> rdata).
module frog_mem128x4 #(
  parameter int AW = 7,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_p,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frog_memctl.sv
// frog memory controller and program loader. Ports: clk, rst_p,
// cpu_bus/cpu_data/cpu_rst (CPU side), load_* (host loader side).
module frog_memctl
  import frog_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_p,
  input  logic [7:0]    cpu_bus,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_rst,
  input  logic          load_req,
  input  logic          load_valid,
  input  logic [DW-1:0] load_nib,
  output logic          load_ready,
  output logic          load_wrap
);

  top_t state, state_nx;
  wst_t wst, wst_nx;

  logic [AW-1:0] waddr;
  logic [AW-1:0] ptr;
  logic          cpu_we;
  logic          ld_we;
  logic          we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] rdata;
  logic          wcyc;
  logic          run_stay;

  assign wcyc = cpu_bus[WCYC_BIT];

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (load_req) state_nx = LOAD;
      LOAD:    if (!load_req) state_nx = RELEASE;
      RELEASE: state_nx = RUN;
      default: state_nx = RELEASE;
    endcase
  end

  // A store still pending when LOAD is requested is dropped.
  assign run_stay = (state == RUN) && (state_nx == RUN);

  always_comb begin
    wst_nx = WIDLE;
    cpu_we = 1'b0;
    if (run_stay) begin
      unique case (wst)
        WIDLE: if (wcyc) wst_nx = WDATA;
        WDATA: if (wcyc) cpu_we = 1'b1;
        default: wst_nx = WIDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state   <= RELEASE;
      wst     <= WIDLE;
      cpu_rst <= 1'b1;
      waddr   <= '0;
    end else begin
      state   <= state_nx;
      wst     <= wst_nx;
      cpu_rst <= (state != RUN);
      if (run_stay && wst == WIDLE && wcyc)
        waddr <= cpu_bus[AW-1:0];
    end
  end

  assign ld_we = (state == LOAD) && load_valid;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      ptr       <= '0;
      load_wrap <= 1'b0;
    end else if (state == RUN && state_nx == LOAD) begin
      ptr       <= '0;
      load_wrap <= 1'b0;
    end else if (ld_we) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) load_wrap <= 1'b1;
    end
  end

  assign we      = cpu_we | ld_we;
  assign m_waddr = ld_we ? ptr : waddr;
  assign m_wdata = ld_we ? load_nib : cpu_bus[DW-1:0];

  frog_mem128x4 #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk  (clk),
    .rst_p(rst_p),
    .we   (we),
    .waddr(m_waddr),
    .wdata(m_wdata),
    .raddr(cpu_bus[AW-1:0]),
    .rdata(rdata)
  );

  assign load_ready = (state == LOAD);
  assign cpu_data   = (state == RUN && !wcyc) ? rdata : '0;

endmodule

// File: tb/tb_frog_memctl.sv
// Directed bench for frog_memctl: reset, load/run, CPU stores,
// loader wrap, load during store and async reset.
module tb_frog_memctl;

  logic       clk = 1'b0;
  logic       rst_p;
  logic [7:0] cpu_bus;
  logic [3:0] cpu_data;
  logic       cpu_rst;
  logic       load_req;
  logic       load_valid;
  logic [3:0] load_nib;
  logic       load_ready;
  logic       load_wrap;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  frog_memctl dut (
    .clk       (clk),
    .rst_p     (rst_p),
    .cpu_bus   (cpu_bus),
    .cpu_data  (cpu_data),
    .cpu_rst   (cpu_rst),
    .load_req  (load_req),
    .load_valid(load_valid),
    .load_nib  (load_nib),
    .load_ready(load_ready),
    .load_wrap (load_wrap)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [6:0] a,
                    input logic [3:0] exp);
    cpu_bus = {1'b0, a};
    #1;
    chk(tag, {4'h0, cpu_data}, {4'h0, exp});
  endtask

  initial begin
    rst_p      = 1'b1;
    cpu_bus    = 8'h00;
    load_req   = 1'b0;
    load_valid = 1'b0;
    load_nib   = 4'h0;
    step();
    step();
    chk("rst_cpu_rst", {7'h0, cpu_rst}, 8'h01);
    chk("rst_ready", {7'h0, load_ready}, 8'h00);
    chk("rst_wrap", {7'h0, load_wrap}, 8'h00);
    @(negedge clk);
    rst_p = 1'b0;
    step();
    chk("rel_edge1_cpu_rst", {7'h0, cpu_rst}, 8'h01);
    rd("rel_rd_02", 7'h02, 4'h0);
    rd("rel_rd_7f", 7'h7f, 4'h0);
    step();
    chk("rel_edge2_cpu_rst", {7'h0, cpu_rst}, 8'h00);

    // load 7,C,0,5
    load_req = 1'b1;
    step();
    chk("ld_ready", {7'h0, load_ready}, 8'h01);
    load_valid = 1'b1;
    load_nib = 4'h7; step();
    load_nib = 4'hC; step();
    load_nib = 4'h0; step();
    load_nib = 4'h5; step();
    chk("ld_cpu_rst", {7'h0, cpu_rst}, 8'h01);
    load_valid = 1'b0;
    load_req = 1'b0;
    step();
    chk("ex_e1_cpu_rst", {7'h0, cpu_rst}, 8'h01);
    chk("ex_e1_ready", {7'h0, load_ready}, 8'h00);
    step();
    chk("ex_e2_cpu_rst", {7'h0, cpu_rst}, 8'h01);
    rd("ld_rd_00", 7'h00, 4'h7);
    rd("ld_rd_01", 7'h01, 4'hC);
    rd("ld_rd_02", 7'h02, 4'h0);
    rd("ld_rd_03", 7'h03, 4'h5);
    rd("ld_rd_04", 7'h04, 4'h0);
    step();
    chk("ex_e3_cpu_rst", {7'h0, cpu_rst}, 8'h00);

    // CPU store 0xA -> 0x05
    cpu_bus = 8'h85;
    #1;
    chk("st_wcyc_data", {4'h0, cpu_data}, 8'h00);
    step();
    cpu_bus = 8'h8A;
    step();
    rd("st_rd_05", 7'h05, 4'hA);
    rd("st_rd_0a", 7'h0A, 4'h0);

    // aborted store to 0x10
    cpu_bus = 8'h90;
    step();
    rd("ab_rd_10a", 7'h10, 4'h0);
    step();
    cpu_bus = 8'h8A;
    step();
    cpu_bus = 8'h00;
    step();
    rd("ab_rd_10b", 7'h10, 4'h0);
    rd("ab_rd_0a", 7'h0A, 4'h0);
    rd("ab_rd_05", 7'h05, 4'hA);

    // wrap: 129 nibbles, last one 0xF
    load_req = 1'b1;
    step();
    for (int i = 0; i < 129; i++) begin
      load_valid = 1'b1;
      load_nib = (i == 128) ? 4'hF : 4'((i * 3 + 1) & 15);
      step();
      if (i == 126) chk("wr_pre_wrap", {7'h0, load_wrap}, 8'h00);
    end
    chk("wr_wrap_set", {7'h0, load_wrap}, 8'h01);
    load_valid = 1'b0;
    load_req = 1'b0;
    step();
    step();
    rd("wr_rd_00", 7'h00, 4'hF);
    rd("wr_rd_01", 7'h01, 4'h4);
    rd("wr_rd_7f", 7'h7F, 4'hE);
    chk("wr_wrap_hold", {7'h0, load_wrap}, 8'h01);
    load_req = 1'b1;
    step();
    chk("wr_wrap_clr", {7'h0, load_wrap}, 8'h00);
    load_valid = 1'b1;
    load_nib = 4'h3;
    step();
    load_valid = 1'b0;
    load_req = 1'b0;
    step();
    step();
    rd("rl_rd_00", 7'h00, 4'h3);
    rd("rl_rd_01", 7'h01, 4'h4);
    step();

    // load_req rising mid-store
    cpu_bus = 8'h83;
    step();
    load_req = 1'b1;
    cpu_bus = 8'h89;
    step();
    cpu_bus = 8'h00;
    step();
    chk("ms_cpu_rst", {7'h0, cpu_rst}, 8'h01);
    load_req = 1'b0;
    step();
    step();
    rd("ms_rd_03", 7'h03, 4'hA);

    // async reset mid-operation
    #2;
    rst_p = 1'b1;
    #1;
    chk("ar_cpu_rst", {7'h0, cpu_rst}, 8'h01);
    chk("ar_data", {4'h0, cpu_data}, 8'h00);
    @(negedge clk);
    rst_p = 1'b0;
    step();
    step();
    rd("ar_rd_00", 7'h00, 4'h0);
    rd("ar_rd_05", 7'h05, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
